// File: rtl/fifo_loader.sv
// Write side of the engine's data/weight FIFOs: fetches data and weight bursts over a
// single-outstanding read port. Optional stall counter: define FIFO_LOADER_PERF_EN.
module fifo_loader #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op_type,
    input  logic              port_sel,
    input  logic [31:0]       op_num,
    input  logic [ADDR_W-1:0] data_base,
    input  logic [ADDR_W-1:0] weight_base,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    input  logic              p0_data_fifo_full,
    input  logic              p0_weight_fifo_full,
    input  logic              p1_data_fifo_full,
    input  logic              p1_weight_fifo_full,
    output logic              p0_data_fifo_wr_en,
    output logic              p0_weight_fifo_wr_en,
    output logic              p1_data_fifo_wr_en,
    output logic              p1_weight_fifo_wr_en,
`ifdef FIFO_LOADER_PERF_EN
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic [15:0]       fifo_din
);

    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, D_REQ, D_WAIT, W_REQ, W_WAIT, FIN
    } state_t;

    state_t            state;
    logic              need_wgt;
    logic              port_r;
    logic              outstanding;
    logic [31:0]       remaining;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [BW-1:0]     blen;
    logic [BW-1:0]     burst_cnt;

    logic              tgt_full;
    logic [ADDR_W-1:0] cur_addr;
    logic [BW-1:0]     blen_next;
    logic              burst_last;
    logic              ret;
    logic              accept;

    // Target FIFO and address follow the phase of the current request state.
    always_comb begin
        tgt_full = port_r ? p1_data_fifo_full : p0_data_fifo_full;
        cur_addr = d_addr;
        if (state == W_REQ) begin
            tgt_full = port_r ? p1_weight_fifo_full : p0_weight_fifo_full;
            cur_addr = w_addr;
        end
    end

    assign blen_next  = (remaining < 32'(BURST_LEN)) ? BW'(remaining) : BW'(BURST_LEN);
    assign burst_last = (burst_cnt + BW'(1)) == blen;
    assign ret        = mem_rd_valid && outstanding;
    assign accept     = (state == IDLE) && start && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            mem_rd_req           <= 1'b0;
            mem_rd_addr          <= '0;
            fifo_din             <= '0;
            p0_data_fifo_wr_en   <= 1'b0;
            p0_weight_fifo_wr_en <= 1'b0;
            p1_data_fifo_wr_en   <= 1'b0;
            p1_weight_fifo_wr_en <= 1'b0;
            need_wgt             <= 1'b0;
            port_r               <= 1'b0;
            outstanding          <= 1'b0;
            remaining            <= '0;
            d_addr               <= '0;
            w_addr               <= '0;
            blen                 <= '0;
            burst_cnt            <= '0;
        end else begin
            done                 <= 1'b0;
            p0_data_fifo_wr_en   <= 1'b0;
            p0_weight_fifo_wr_en <= 1'b0;
            p1_data_fifo_wr_en   <= 1'b0;
            p1_weight_fifo_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    // busy stays high through the done cycle and drops here
                    busy <= accept;
                    if (accept) begin
                        need_wgt  <= op_type inside {3'd1, 3'd2, 3'd3};
                        port_r    <= port_sel;
                        remaining <= op_num;
                        d_addr    <= data_base;
                        w_addr    <= weight_base;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (remaining == 32'd0) begin
                        state <= FIN;
                    end else begin
                        blen      <= blen_next;
                        burst_cnt <= '0;
                        state     <= D_REQ;
                    end
                end
                D_REQ, W_REQ: begin
                    if (mem_rd_req && mem_rd_gnt) begin
                        mem_rd_req  <= 1'b0;
                        outstanding <= 1'b1;
                        state       <= (state == D_REQ) ? D_WAIT : W_WAIT;
                    end else if (!mem_rd_req) begin
                        mem_rd_req  <= !tgt_full;
                        mem_rd_addr <= cur_addr;
                    end
                end
                D_WAIT: begin
                    if (ret) begin
                        outstanding <= 1'b0;
                        fifo_din    <= mem_rd_data;
                        if (port_r) p1_data_fifo_wr_en <= 1'b1;
                        else        p0_data_fifo_wr_en <= 1'b1;
                        d_addr    <= d_addr + ADDR_W'(1);
                        burst_cnt <= burst_cnt + BW'(1);
                        if (burst_last) begin
                            burst_cnt <= '0;
                            remaining <= remaining - 32'(blen);
                            state     <= need_wgt ? W_REQ : LOAD;
                        end else begin
                            state <= D_REQ;
                        end
                    end
                end
                W_WAIT: begin
                    if (ret) begin
                        outstanding <= 1'b0;
                        fifo_din    <= mem_rd_data;
                        if (port_r) p1_weight_fifo_wr_en <= 1'b1;
                        else        p0_weight_fifo_wr_en <= 1'b1;
                        w_addr    <= w_addr + ADDR_W'(1);
                        burst_cnt <= burst_cnt + BW'(1);
                        state     <= burst_last ? LOAD : W_REQ;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_LOADER_PERF_EN
    // Cycles spent waiting in a request state, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (accept) begin
            perf_stall_cnt <= '0;
        end else if ((state == D_REQ || state == W_REQ) && (tgt_full || !mem_rd_gnt)
                     && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_loader.sv
// Self-checking bench for fifo_loader: directed cases plus randomized ops against a
// burst-level reference of the expected FIFO write stream and request addresses.
module tb_fifo_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op_type;
    logic        port_sel;
    logic [31:0] op_num;
    logic [31:0] data_base;
    logic [31:0] weight_base;
    logic        busy;
    logic        done;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_gnt;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;
    logic        p0_data_fifo_full, p0_weight_fifo_full, p1_data_fifo_full, p1_weight_fifo_full;
    logic        p0_data_fifo_wr_en, p0_weight_fifo_wr_en, p1_data_fifo_wr_en, p1_weight_fifo_wr_en;
    logic [15:0] fifo_din;
`ifdef FIFO_LOADER_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    fifo_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_type(op_type), .port_sel(port_sel),
        .op_num(op_num), .data_base(data_base), .weight_base(weight_base),
        .busy(busy), .done(done), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .p0_data_fifo_full(p0_data_fifo_full), .p0_weight_fifo_full(p0_weight_fifo_full),
        .p1_data_fifo_full(p1_data_fifo_full), .p1_weight_fifo_full(p1_weight_fifo_full),
        .p0_data_fifo_wr_en(p0_data_fifo_wr_en), .p0_weight_fifo_wr_en(p0_weight_fifo_wr_en),
        .p1_data_fifo_wr_en(p1_data_fifo_wr_en), .p1_weight_fifo_wr_en(p1_weight_fifo_wr_en),
`ifdef FIFO_LOADER_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .fifo_din(fifo_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Environment state shared between the memory/FIFO model and the main sequence.
    int          got_q[$];
    logic [31:0] req_q[$];
    int          done_cnt, req_cycles, got_at_done;
    bit          rand_full, gnt_rand, pend;
    int          vmin, vmax, cd, stall_arm, stall_hold;
    logic [31:0] pend_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'hC35A;
    endfunction

    // Memory responder, FIFO-full driver and write monitor, all stepping 1 ns after the edge.
    initial begin
        mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        p0_data_fifo_full = 1'b0; p0_weight_fifo_full = 1'b0;
        p1_data_fifo_full = 1'b0; p1_weight_fifo_full = 1'b0;
        pend = 1'b0; cd = 0; stall_hold = 0;
        forever begin
            @(posedge clk); #1;
            if (p0_data_fifo_wr_en)   got_q.push_back((0 << 16) | 32'(fifo_din));
            if (p0_weight_fifo_wr_en) got_q.push_back((1 << 16) | 32'(fifo_din));
            if (p1_data_fifo_wr_en)   got_q.push_back((2 << 16) | 32'(fifo_din));
            if (p1_weight_fifo_wr_en) got_q.push_back((3 << 16) | 32'(fifo_din));
            if (mem_rd_req) req_cycles++;
            if (done) begin
                done_cnt++;
                got_at_done = got_q.size();
            end
            if (stall_hold > 0) begin
                check("stall_req_low", 32'(mem_rd_req), 32'd0);
                stall_hold--;
            end
            if (stall_arm >= 0 && got_q.size() == stall_arm) begin
                stall_hold = 10;
                stall_arm  = -1;
            end
            p0_data_fifo_full   = (stall_hold > 0) || (rand_full && $urandom_range(0, 3) == 0);
            p0_weight_fifo_full = rand_full && $urandom_range(0, 3) == 0;
            p1_data_fifo_full   = rand_full && $urandom_range(0, 3) == 0;
            p1_weight_fifo_full = rand_full && $urandom_range(0, 3) == 0;
            mem_rd_gnt   = 1'b0;
            mem_rd_valid = 1'b0;
            if (pend) begin
                if (cd == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    cd--;
                end
            end else if (mem_rd_req && (!gnt_rand || $urandom_range(0, 1) == 1)) begin
                mem_rd_gnt = 1'b1;
                pend       = 1'b1;
                cd         = $urandom_range(vmin, vmax);
                pend_addr  = mem_rd_addr;
                req_q.push_back(mem_rd_addr);
            end
        end
    end

    // Runs one operation and compares the write stream and request addresses to the reference.
    task automatic run_op(input logic [2:0] op, input logic ps, input int n,
                          input logic [31:0] db, input logic [31:0] wb, input bit poke);
        int          exp_q[$];
        logic [31:0] exp_a[$];
        int          rem, b, cyc, id;
        logic [31:0] d, w;
        bit          nw;
        nw  = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        id  = ps ? 2 : 0;
        rem = n; d = db; w = wb;
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
            for (int i = 0; i < b; i++) begin
                exp_a.push_back(d);
                exp_q.push_back((id << 16) | 32'(mem_word(d)));
                d = d + 32'd1;
            end
            if (nw) begin
                for (int i = 0; i < b; i++) begin
                    exp_a.push_back(w);
                    exp_q.push_back(((id + 1) << 16) | 32'(mem_word(w)));
                    w = w + 32'd1;
                end
            end
            rem -= b;
        end
        got_q.delete(); req_q.delete();
        done_cnt = 0; req_cycles = 0; got_at_done = -1;
        @(posedge clk); #2;
        op_type = op; port_sel = ps; op_num = n; data_base = db; weight_base = wb; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 6000) begin
            @(posedge clk); #2;
            cyc++;
            start = poke && (cyc == 20);
            if (poke && cyc == 20) begin
                op_num = 32'd3; op_type = 3'd5; port_sel = ~ps;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        if (n == 0) begin
            check("zero_len_latency", 32'(cyc <= 3), 32'd1);
            check("zero_len_no_req", 32'(req_cycles), 32'd0);
        end
        repeat (3) @(posedge clk);
        #2;
        check("done_once", 32'(done_cnt), 32'd1);
        check("busy_cleared", 32'(busy), 32'd0);
        check("writes_before_done", 32'(got_at_done), 32'(exp_q.size()));
        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        check("req_count", 32'(req_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("write[%0d]", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_q[i]));
        for (int i = 0; i < exp_a.size(); i++)
            check($sformatf("addr[%0d]", i), (i < req_q.size()) ? req_q[i] : 32'hDEAD_BEEF, exp_a[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_req"},  32'(mem_rd_req), 32'd0);
        check({tag, "_addr"}, mem_rd_addr, 32'd0);
        check({tag, "_wr_en"}, 32'({p1_weight_fifo_wr_en, p1_data_fifo_wr_en,
                                    p0_weight_fifo_wr_en, p0_data_fifo_wr_en}), 32'd0);
        check({tag, "_din"},  32'(fifo_din), 32'd0);
`ifdef FIFO_LOADER_PERF_EN
        check({tag, "_perf"}, perf_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; op_type = '0; port_sel = 1'b0; op_num = '0;
        data_base = '0; weight_base = '0;
        rand_full = 1'b0; gnt_rand = 1'b0; vmin = 1; vmax = 1; stall_arm = -1;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // CONV3 full burst, immediate grant, data two cycles after grant
        run_op(3'd2, 1'b0, 16, 32'h0000_1000, 32'h0000_8000, 1'b0);
        // APOOL on port 1: data only
        run_op(3'd5, 1'b1, 5, 32'h0000_2000, 32'h0000_9000, 1'b0);
        // CONV1, 16/16/5 bursts, with an ignored start mid-transfer
        run_op(3'd1, 1'b0, 37, 32'h0000_3000, 32'h0000_A000, 1'b1);
        // Data FIFO full for 10 cycles before word 3
        stall_arm = 3;
        run_op(3'd4, 1'b0, 8, 32'h0000_4000, 32'h0000_B000, 1'b0);
`ifdef FIFO_LOADER_PERF_EN
        check("perf_stall_ge_10", 32'(perf_stall_cnt >= 32'd10), 32'd1);
`endif
        // Zero-length op
        run_op(3'd3, 1'b1, 0, 32'h0000_5000, 32'h0000_C000, 1'b0);

        // Reset while waiting for data, then a stray return
        vmin = 6; vmax = 6;
        got_q.delete(); req_q.delete();
        @(posedge clk); #2;
        op_type = 3'd2; port_sel = 1'b0; op_num = 32'd16;
        data_base = 32'h0000_6000; weight_base = 32'h0000_D000; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc = 0;
        while (req_q.size() == 0 && cyc < 50) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("reset_test_granted", 32'(req_q.size()), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("stray_valid_delivered", 32'(pend), 32'd0);
        check("stray_no_writes", 32'(got_q.size()), 32'd0);
        check_outputs_zero("after_stray");
        vmin = 1; vmax = 1;
        run_op(3'd1, 1'b0, 0, 32'h0, 32'h0, 1'b0);

        // Randomized ops with random grant/return latency and FIFO back-pressure
        gnt_rand = 1'b1; vmin = 0; vmax = 3; rand_full = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] db;
            db = (k == 0) ? 32'hFFFF_FFF8 : $urandom;
            run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 40),
                   db, (k == 1) ? 32'hFFFF_FFFA : $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
